// File: rtl/risc16_pkg.sv
// risc16_pkg: shared definitions for the RiSC-16 multi-cycle control unit.
//   opcode_e    - instruction opcodes held in IR[15:13]
//   state_e     - control sequencer states
//   mux_tgt_e   - register-file write-data select encodings
//   mux_pc_e    - PC next-value select encodings
//   mux_alu2_e  - ALU second-operand select encodings
//   func_alu_e  - ALU function encodings
//   is_halt()   - HALT decode (JALR opcode with a non-zero low immediate)
package risc16_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    TGT_MEM = 2'b00,
    TGT_ALU = 2'b01,
    TGT_PC1 = 2'b10
  } mux_tgt_e;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_REG    = 2'b10
  } mux_pc_e;

  typedef enum logic [1:0] {
    ALU2_REG  = 2'b00,
    ALU2_SIMM = 2'b01,
    ALU2_LUI  = 2'b10
  } mux_alu2_e;

  typedef enum logic [1:0] {
    FN_ADD   = 2'b00,
    FN_NAND  = 2'b01,
    FN_PASS2 = 2'b10,
    FN_CMP   = 2'b11
  } func_alu_e;

  // HALT shares the JALR opcode; a non-zero IR[6:0] distinguishes it.
  function automatic logic is_halt(input logic [2:0] op, input logic [6:0] imm7);
    return (op == OP_JALR) && (imm7 != '0);
  endfunction

endpackage

// File: rtl/risc16_imm_gen.sv
// risc16_imm_gen: combinational immediate formatting from the instruction register.
//   i_field    in  10  IR[9:0]
//   o_simm_ext out DW  IR[6:0] sign-extended to DW bits
//   o_lui_imm  out DW  {IR[9:0], 6'b0}
module risc16_imm_gen #(
  parameter int unsigned DW = 16
) (
  input  logic [9:0]    i_field,
  output logic [DW-1:0] o_simm_ext,
  output logic [DW-1:0] o_lui_imm
);

  assign o_simm_ext = {{(DW-7){i_field[6]}}, i_field[6:0]};
  assign o_lui_imm  = {i_field, {(DW-10){1'b0}}};

endmodule

// File: rtl/risc16_control_fsm.sv
// risc16_control_fsm: multi-cycle control unit for the 16-bit RiSC datapath.
// Holds the instruction register and sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack handshakes to instruction and data memories.
//   clk, rst            clock; synchronous active-high reset
//   imem_data/imem_ack  fetched instruction and fetch completion
//   dmem_ack            data access completion
//   alu_eq              ALU equality flag for BEQ
//   imem_req/dmem_req   memory requests, held until acknowledged
//   WE_dmem             1 = store, 0 = load (while dmem_req)
//   rA/rB/rC            register indices IR[12:10], IR[9:7], IR[2:0]
//   MUX_rf/MUX_tgt/WE_rf  register-file port-2 select, write-data select, write strobe
//   FUNC_alu/MUX_alu2   ALU function and operand-2 select
//   simm_ext/lui_imm    formatted immediates
//   WE_pc/MUX_pc        PC write strobe and next-PC select
//   retire/halted       instruction-complete pulse; HALT state indicator
module risc16_control_fsm
  import risc16_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] imem_data,
  input  logic          imem_ack,
  input  logic          dmem_ack,
  input  logic          alu_eq,
  output logic          imem_req,
  output logic          dmem_req,
  output logic          WE_dmem,
  output logic [RW-1:0] rA,
  output logic [RW-1:0] rB,
  output logic [RW-1:0] rC,
  output logic          MUX_rf,
  output logic [1:0]    MUX_tgt,
  output logic          WE_rf,
  output logic [1:0]    FUNC_alu,
  output logic [1:0]    MUX_alu2,
  output logic [DW-1:0] simm_ext,
  output logic [DW-1:0] lui_imm,
  output logic          WE_pc,
  output logic [1:0]    MUX_pc,
  output logic          retire,
  output logic          halted
);

  state_e        r_state;
  state_e        w_next;
  logic [DW-1:0] r_ir;
  opcode_e       w_op;
  logic          w_we_rf;
  logic          w_we_pc;
  logic          w_retire;

  assign w_op = opcode_e'(r_ir[15:13]);

  assign rA = r_ir[12:10];
  assign rB = r_ir[9:7];
  assign rC = r_ir[2:0];

  risc16_imm_gen #(
    .DW(DW)
  ) u_imm_gen (
    .i_field   (r_ir[9:0]),
    .o_simm_ext(simm_ext),
    .o_lui_imm (lui_imm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ack) begin
        r_ir <= imem_data;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    WE_dmem  = 1'b0;
    MUX_rf   = 1'b0;
    MUX_tgt  = '0;
    FUNC_alu = '0;
    MUX_alu2 = '0;
    MUX_pc   = '0;
    w_we_rf  = 1'b0;
    w_we_pc  = 1'b0;
    w_retire = 1'b0;

    // Datapath selects are a pure function of the opcode once IR is loaded.
    if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      MUX_tgt = TGT_ALU;
      unique case (w_op)
        OP_ADD:  FUNC_alu = FN_ADD;
        OP_ADDI: MUX_alu2 = ALU2_SIMM;
        OP_NAND: FUNC_alu = FN_NAND;
        OP_LUI: begin
          FUNC_alu = FN_PASS2;
          MUX_alu2 = ALU2_LUI;
        end
        OP_SW: begin
          MUX_alu2 = ALU2_SIMM;
          MUX_rf   = 1'b1;
        end
        OP_LW: begin
          MUX_alu2 = ALU2_SIMM;
          MUX_tgt  = TGT_MEM;
        end
        OP_BEQ: begin
          FUNC_alu = FN_CMP;
          MUX_rf   = 1'b1;
        end
        OP_JALR: MUX_tgt = TGT_PC1;
      endcase
    end

    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: w_next = is_halt(r_ir[15:13], r_ir[6:0]) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_op == OP_BEQ) begin
          w_we_pc  = 1'b1;
          w_retire = 1'b1;
          MUX_pc   = alu_eq ? PC_BRANCH : PC_INC;
          w_next   = S_FETCH;
        end else if (w_op == OP_SW || w_op == OP_LW) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        WE_dmem  = (w_op == OP_SW);
        if (dmem_ack) begin
          if (w_op == OP_SW) begin
            w_we_pc  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_we_rf  = 1'b1;
        w_we_pc  = 1'b1;
        w_retire = 1'b1;
        if (w_op == OP_JALR) MUX_pc = PC_REG;
        w_next = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset in the same cycle suppresses any commit the current state would make,
  // so an abandoned instruction never writes architectural state.
  assign WE_rf  = w_we_rf  & ~rst;
  assign WE_pc  = w_we_pc  & ~rst;
  assign retire = w_retire & ~rst;
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_risc16_control_fsm.sv
module tb_risc16_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_data = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        alu_eq = 1'b0;
  logic        imem_req, dmem_req, WE_dmem, MUX_rf, WE_rf, WE_pc, retire, halted;
  logic [2:0]  rA, rB, rC;
  logic [1:0]  MUX_tgt, FUNC_alu, MUX_alu2, MUX_pc;
  logic [15:0] simm_ext, lui_imm;

  risc16_control_fsm #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst(rst), .imem_data(imem_data), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .alu_eq(alu_eq), .imem_req(imem_req), .dmem_req(dmem_req),
    .WE_dmem(WE_dmem), .rA(rA), .rB(rB), .rC(rC), .MUX_rf(MUX_rf), .MUX_tgt(MUX_tgt),
    .WE_rf(WE_rf), .FUNC_alu(FUNC_alu), .MUX_alu2(MUX_alu2), .simm_ext(simm_ext),
    .lui_imm(lui_imm), .WE_pc(WE_pc), .MUX_pc(MUX_pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned exec_cyc;
    int unsigned ret_cyc;
    logic        we_rf, mem, store, alu_care, rf_care, rf;
    logic [1:0]  tgt, pc, func, alu2;
    logic [15:0] simm, lui;
    logic [2:0]  ra, rb, rc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned retired = 0;
  int unsigned issued = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what each instruction must do, counted in cycles from the
  // cycle in which the fetch is acknowledged (ack_c).
  function automatic exp_t model(input logic [15:0] ir, input logic eq,
                                 input int unsigned ack_c, input int unsigned dw);
    exp_t        e;
    int unsigned op, lat;
    int          s;
    op = 32'(ir) >> 13;
    s  = int'(32'(ir) & 32'h7F);
    if (s >= 64) s = s - 128;
    e.simm = 16'(s);
    e.lui  = 16'((32'(ir) & 32'h3FF) * 64);
    e.ra   = 3'((32'(ir) >> 10) & 7);
    e.rb   = 3'((32'(ir) >> 7) & 7);
    e.rc   = 3'(32'(ir) & 7);
    e.we_rf = 1'b1; e.tgt = 2'b01; e.pc = 2'b00; e.func = 2'b00; e.alu2 = 2'b00;
    e.mem = 1'b0; e.store = 1'b0; e.alu_care = 1'b1; e.rf_care = 1'b0; e.rf = 1'b0;
    lat = 3;
    case (op)
      0: begin e.rf_care = 1'b1; end
      1: e.alu2 = 2'b01;
      2: begin e.func = 2'b01; e.rf_care = 1'b1; end
      3: begin e.func = 2'b10; e.alu2 = 2'b10; end
      4: begin e.mem = 1'b1; e.store = 1'b1; e.alu2 = 2'b01; e.we_rf = 1'b0; lat = 3 + dw; end
      5: begin e.mem = 1'b1; e.alu2 = 2'b01; e.tgt = 2'b00; lat = 4 + dw; end
      6: begin e.func = 2'b11; e.rf = 1'b1; e.rf_care = 1'b1; e.we_rf = 1'b0;
               e.pc = eq ? 2'b01 : 2'b00; lat = 2; end
      default: begin e.tgt = 2'b10; e.pc = 2'b10; e.alu_care = 1'b0; end
    endcase
    e.exec_cyc = ack_c + 2;
    e.ret_cyc  = ack_c + lat;
    return e;
  endfunction

  // Monitor: compares DUT activity against the front of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0 && cyc == sb[0].exec_cyc) begin
        e = sb[0];
        chk("exec_rA", 32'(rA), 32'(e.ra));
        chk("exec_rB", 32'(rB), 32'(e.rb));
        chk("exec_rC", 32'(rC), 32'(e.rc));
        chk("exec_simm_ext", 32'(simm_ext), 32'(e.simm));
        chk("exec_lui_imm", 32'(lui_imm), 32'(e.lui));
        if (e.alu_care) begin
          chk("exec_FUNC_alu", 32'(FUNC_alu), 32'(e.func));
          chk("exec_MUX_alu2", 32'(MUX_alu2), 32'(e.alu2));
        end
        if (e.rf_care) chk("exec_MUX_rf", 32'(MUX_rf), 32'(e.rf));
      end
      if (dmem_req && sb.size() != 0) begin
        e = sb[0];
        chk("dmem_req_for_mem_op", 32'(e.mem), 1);
        chk("WE_dmem", 32'(WE_dmem), 32'(e.store));
        if (e.store) chk("mem_MUX_rf", 32'(MUX_rf), 1);
      end
      if (retire || WE_rf || WE_pc) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'({retire, WE_rf, WE_pc}), 0);
        end else begin
          e = sb.pop_front();
          retired++;
          chk("retire_cycle", cyc, e.ret_cyc);
          chk("retire", 32'(retire), 1);
          chk("WE_pc", 32'(WE_pc), 1);
          chk("WE_rf", 32'(WE_rf), 32'(e.we_rf));
          chk("MUX_pc", 32'(MUX_pc), 32'(e.pc));
          if (e.we_rf) chk("MUX_tgt", 32'(MUX_tgt), 32'(e.tgt));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int unsigned n = 0;
    while (!imem_req && n < 100) begin
      dmem_ack = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    dmem_ack = 1'b0;
    chk("fetch_req", 32'(imem_req), 1);
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic eq,
                           input int unsigned wi, input int unsigned wd);
    exp_t        e;
    int unsigned n = 0;
    wait_fetch();
    if (!imem_req) return;
    for (int unsigned i = 0; i < wi; i++) begin
      imem_data = 16'($urandom);
      step();
    end
    imem_data = ir;
    imem_ack  = 1'b1;
    alu_eq    = eq;
    e = model(ir, eq, cyc, wd);
    sb.push_back(e);
    issued++;
    step();
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    if (e.mem) begin
      while (!dmem_req && n < 20) begin
        imem_ack = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      imem_ack = 1'b0;
      chk("mem_req", 32'(dmem_req), 1);
      if (!dmem_req) return;
      for (int unsigned i = 0; i < wd; i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        step();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] ir;
    int unsigned n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 32'({imem_req, dmem_req, WE_dmem, WE_rf, WE_pc, retire, halted, MUX_rf}), 0);
    chk("rst_muxes", 32'({MUX_tgt, FUNC_alu, MUX_alu2, MUX_pc}), 0);
    chk("rst_indices", 32'({rA, rB, rC}), 0);
    chk("rst_imm", 32'({simm_ext, lui_imm}), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'(imem_req), 0);
    step();
    @(negedge clk);
    chk("idle_to_fetch", 32'(imem_req), 1);
    step();

    // Directed examples, then randomized stream
    run_instr(16'h2405, 1'b0, 0, 0);
    run_instr(16'hB480, 1'b0, 0, 3);
    run_instr(16'hC57F, 1'b1, 0, 0);
    run_instr(16'hFD80, 1'b0, 0, 0);
    for (int unsigned k = 0; k < 60; k++) begin
      ir = 16'($urandom);
      if (ir[15:13] == 3'b111) ir[6:0] = '0;
      run_instr(ir, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 0);
    chk("retire_count", retired, issued);

    // Reset while a store waits in MEM; late ack afterwards is ignored
    wait_fetch();
    imem_data = 16'h8481;
    imem_ack  = 1'b1;
    step();
    imem_ack = 1'b0;
    n = 0;
    while (!dmem_req && n < 20) begin
      step();
      n++;
    end
    chk("abort_mem_req", 32'(dmem_req), 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_no_commit", 32'({WE_pc, WE_rf, retire}), 0);
    step();
    rst      = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("abort_req_dropped", 32'({dmem_req, imem_req}), 0);
    chk("abort_ir_cleared", 32'(rA), 0);
    step();
    @(negedge clk);
    chk("abort_refetch", 32'({imem_req, WE_pc, retire}), 32'h4);
    step();
    dmem_ack = 1'b0;

    // Reset coincident with fetch ack: nothing latched
    imem_data = 16'h2405;
    imem_ack  = 1'b1;
    rst       = 1'b1;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("rst_ack_ir", 32'(rA), 0);
    chk("rst_ack_idle", 32'(imem_req), 0);
    step();

    // HALT is absorbing until reset
    wait_fetch();
    imem_data = 16'hE001;
    imem_ack  = 1'b1;
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("halt_decode", 32'(halted), 0);
    step();
    for (int unsigned i = 0; i < 20; i++) begin
      imem_ack  = 1'($urandom_range(0, 1));
      dmem_ack  = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
      @(negedge clk);
      chk("halt_hold", 32'({imem_req, dmem_req, WE_pc, WE_rf, retire, halted}), 1);
      step();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("halt_rst_idle", 32'({halted, imem_req}), 0);
    step();
    @(negedge clk);
    chk("halt_rst_fetch", 32'(imem_req), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
